// File: rtl/alu_pkg.sv
// ALU issue stage shared definitions: operation codes, opcode constants and the
// decoder result record.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_SLL = 4'b0100,
      OP_SRL = 4'b0101,
      OP_XOR = 4'b0110,
      OP_SRA = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_BNE = 4'b1001,
      OP_BLT = 4'b1010,
      OP_BGE = 4'b1011,
      OP_SLT = 4'b1100,
      OP_LUI = 4'b1111
   } alu_op_e;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef struct packed {
      alu_op_e operation;
      logic    use_imm;
      logic    is_branch;
      logic    illegal;
   } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7 into the ALU operation code,
// SrcB select, branch flag and illegal-encoding flag.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output dec_t       dec
);

   logic f7_base;
   logic f7_alt;

   assign f7_base = (funct7 == F7_BASE);
   assign f7_alt  = (funct7 == F7_ALT);

   // Map the instruction fields onto an operation; illegal encodings force AND (0000)
   always_comb begin
      dec = '{operation: OP_AND, use_imm: 1'b0, is_branch: 1'b0, illegal: 1'b0};
      case (opcode)
         OPC_RTYPE: begin
            case (funct3)
               3'b000: begin
                  if (f7_base)     dec.operation = OP_ADD;
                  else if (f7_alt) dec.operation = OP_SUB;
                  else             dec.illegal   = 1'b1;
               end
               3'b101: begin
                  if (f7_base)     dec.operation = OP_SRL;
                  else if (f7_alt) dec.operation = OP_SRA;
                  else             dec.illegal   = 1'b1;
               end
               3'b111: begin
                  dec.operation = OP_AND;
                  dec.illegal   = !f7_base;
               end
               3'b110: begin
                  dec.operation = OP_OR;
                  dec.illegal   = !f7_base;
               end
               3'b100: begin
                  dec.operation = OP_XOR;
                  dec.illegal   = !f7_base;
               end
               3'b001: begin
                  dec.operation = OP_SLL;
                  dec.illegal   = !f7_base;
               end
               3'b010: begin
                  dec.operation = OP_SLT;
                  dec.illegal   = !f7_base;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_ITYPE: begin
            // funct7 is immediate data here except for the shift-immediates
            dec.use_imm = 1'b1;
            case (funct3)
               3'b000: dec.operation = OP_ADD;
               3'b111: dec.operation = OP_AND;
               3'b110: dec.operation = OP_OR;
               3'b100: dec.operation = OP_XOR;
               3'b010: dec.operation = OP_SLT;
               3'b001: begin
                  dec.operation = OP_SLL;
                  dec.illegal   = !f7_base;
               end
               3'b101: begin
                  if (f7_base)     dec.operation = OP_SRL;
                  else if (f7_alt) dec.operation = OP_SRA;
                  else             dec.illegal   = 1'b1;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_LOAD, OPC_STORE: begin
            dec.operation = OP_ADD;
            dec.use_imm   = 1'b1;
         end
         OPC_BRANCH: begin
            dec.is_branch = 1'b1;
            case (funct3)
               3'b000:  dec.operation = OP_BEQ;
               3'b001:  dec.operation = OP_BNE;
               3'b100:  dec.operation = OP_BLT;
               3'b101:  dec.operation = OP_BGE;
               default: dec.illegal   = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec.operation = OP_LUI;
            dec.use_imm   = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) dec.operation = OP_AND;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the instruction, selects SrcA/SrcB and registers the
// operands into a valid/ready stage feeding the ALU; counts issued operations.
// Build option ALU_ISSUE_SKID_EN: 2-entry skid buffer with registered in_ready.
// Without it a single output register with in_ready = !out_valid | out_ready.
//
// state    | meaning (ALU_ISSUE_SKID_EN only)
// EMPTY    | nothing held, out_valid low
// ONE      | main entry on out_*, skid free
// TWO      | main entry on out_*, skid holds the next one, in_ready low
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               in_opcode,
   input  logic [2:0]               in_funct3,
   input  logic [6:0]               in_funct7,
   input  logic [DATA_WIDTH-1:0]    in_rs1_data,
   input  logic [DATA_WIDTH-1:0]    in_rs2_data,
   input  logic [DATA_WIDTH-1:0]    in_imm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_srca,
   output logic [DATA_WIDTH-1:0]    out_srcb,
   output logic [OPCODE_LENGTH-1:0] out_operation,
   output logic                     out_is_branch,
   output logic                     out_illegal,
   output logic [31:0]              out_issue_cnt
);

   localparam int ENTRY_W = 2*DATA_WIDTH + OPCODE_LENGTH + 2;

   dec_t               dec;
   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] main_q;
   logic               accept;
   logic               issue;

   alu_op_decode u_decode (
      .opcode (in_opcode),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .dec    (dec)
   );

   assign in_entry = {in_rs1_data,
                      (dec.use_imm ? in_imm : in_rs2_data),
                      OPCODE_LENGTH'(dec.operation),
                      dec.is_branch,
                      dec.illegal};

   assign {out_srca, out_srcb, out_operation, out_is_branch, out_illegal} = main_q;

   assign accept = in_valid & in_ready;
   assign issue  = out_valid & out_ready;

`ifdef ALU_ISSUE_SKID_EN
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic [ENTRY_W-1:0] skid_q;
   logic               in_ready_q;

   // in_ready is a flop; the reset term only holds it low while reset is high
   assign in_ready  = in_ready_q & ~reset;
   assign out_valid = (state_q != ST_EMPTY);

   // Occupancy transitions; accept and issue together keep the count unchanged
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_ONE;
         ST_ONE: begin
            if (accept && !issue)      state_d = ST_TWO;
            else if (issue && !accept) state_d = ST_EMPTY;
         end
         ST_TWO:   if (issue) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // State, registered ready and the two entries; skid drains into main in order
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
         case (state_q)
            ST_EMPTY: if (accept) main_q <= in_entry;
            ST_ONE: begin
               if (accept && issue) main_q <= in_entry;
               else if (accept)     skid_q <= in_entry;
            end
            ST_TWO:   if (issue) main_q <= skid_q;
            default: ;
         endcase
      end
   end
`else
   assign in_ready = ~reset & (~out_valid | out_ready);

   // Single output register; loads whenever it is empty or being drained
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         main_q    <= '0;
      end else if (!out_valid || out_ready) begin
         out_valid <= in_valid;
         if (in_valid) main_q <= in_entry;
      end
   end
`endif

   // Count completed output handshakes, wrapping at 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      out_issue_cnt <= '0;
      else if (issue) out_issue_cnt <= out_issue_cnt + 32'd1;
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, back-to-back flow, stall
// hold, counter wrap and reset while entries are held.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_srca;
   logic [31:0] out_srcb;
   logic [3:0]  out_operation;
   logic        out_is_branch;
   logic        out_illegal;
   logic [31:0] out_issue_cnt;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_cnt = 32'd0;

   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opcode     (in_opcode),
      .in_funct3     (in_funct3),
      .in_funct7     (in_funct7),
      .in_rs1_data   (in_rs1_data),
      .in_rs2_data   (in_rs2_data),
      .in_imm        (in_imm),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_srca      (out_srca),
      .out_srcb      (out_srcb),
      .out_operation (out_operation),
      .out_is_branch (out_is_branch),
      .out_illegal   (out_illegal),
      .out_issue_cnt (out_issue_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
      in_opcode   = opc;
      in_funct3   = f3;
      in_funct7   = f7;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
      in_imm      = imm;
   endtask

   // One instruction through an idle stage: accept, inspect while stalled, drain
   task automatic send_check(input string tag,
                             input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                             input logic [3:0] e_op, input logic [31:0] e_a, input logic [31:0] e_b,
                             input logic e_br, input logic e_ill);
      int k;
      @(negedge clk);
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_rdy"}, in_ready, 1);
      drive(opc, f3, f7, rs1, rs2, imm);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_vld"}, out_valid, 1);
      chk({tag, "_op"},  out_operation, e_op);
      chk({tag, "_a"},   out_srca, e_a);
      chk({tag, "_b"},   out_srcb, e_b);
      chk({tag, "_br"},  out_is_branch, e_br);
      chk({tag, "_ill"}, out_illegal, e_ill);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      chk({tag, "_drain"}, out_valid, 0);
      chk({tag, "_cnt"},   out_issue_cnt, exp_cnt);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_vld",   out_valid, 0);
      chk("rst_rdy",   in_ready, 0);
      chk("rst_cnt",   out_issue_cnt, 0);
      chk("rst_op",    out_operation, 0);
      chk("rst_srca",  out_srca, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rel_rdy",   in_ready, 1);

      // decode vectors
      send_check("sub",   7'b0110011, 3'b000, 7'h20, 32'd7, 32'd3, 32'h55,
                 4'b0011, 32'd7, 32'd3, 1'b0, 1'b0);
      send_check("add",   7'b0110011, 3'b000, 7'h00, 32'd10, 32'd20, 32'h55,
                 4'b0010, 32'd10, 32'd20, 1'b0, 1'b0);
      send_check("srai",  7'b0010011, 3'b101, 7'h20, 32'h8000_0000, 32'd9, 32'h405,
                 4'b0111, 32'h8000_0000, 32'h405, 1'b0, 1'b0);
      send_check("xori",  7'b0010011, 3'b100, 7'h7F, 32'h0F0F, 32'd1, 32'hFFFF_FFF0,
                 4'b0110, 32'h0F0F, 32'hFFFF_FFF0, 1'b0, 1'b0);
      send_check("lui",   7'b0110111, 3'b011, 7'h12, 32'h11, 32'h22, 32'h1234_5000,
                 4'b1111, 32'h11, 32'h1234_5000, 1'b0, 1'b0);
      send_check("load",  7'b0000011, 3'b010, 7'h00, 32'h1000, 32'h99, 32'h8,
                 4'b0010, 32'h1000, 32'h8, 1'b0, 1'b0);
      send_check("bge",   7'b1100011, 3'b101, 7'h00, 32'd5, 32'd6, 32'h10,
                 4'b1011, 32'd5, 32'd6, 1'b1, 1'b0);
      send_check("br010", 7'b1100011, 3'b010, 7'h00, 32'd1, 32'd8, 32'h10,
                 4'b0000, 32'd1, 32'd8, 1'b1, 1'b1);
      send_check("badop", 7'b1111111, 3'b000, 7'h00, 32'd2, 32'd4, 32'h30,
                 4'b0000, 32'd2, 32'd4, 1'b0, 1'b1);
      send_check("badf7", 7'b0110011, 3'b000, 7'h01, 32'd3, 32'd5, 32'h30,
                 4'b0000, 32'd3, 32'd5, 1'b0, 1'b1);

      // back-to-back: 8 accepts, 8 consecutive valid cycles
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(7'b0110011, 3'b000, 7'h00, 32'(i), 32'd100, 32'd0);
         in_valid = 1'b1;
         chk("b2b_rdy", in_ready, 1);
         @(negedge clk);
         chk("b2b_vld",  out_valid, 1);
         chk("b2b_srca", out_srca, 32'(i));
      end
      in_valid = 1'b0;
      @(negedge clk);
      exp_cnt = exp_cnt + 32'd8;
      chk("b2b_end", out_valid, 0);
      chk("b2b_cnt", out_issue_cnt, exp_cnt);
      out_ready = 1'b0;

      // stall: output held stable while in_valid stays high
      @(negedge clk);
      drive(7'b0110011, 3'b000, 7'h20, 32'hA0, 32'hA1, 32'd0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stl_a", out_srca, 32'hA0);
      drive(7'b0110011, 3'b111, 7'h00, 32'hB0, 32'hB1, 32'd0);
`ifdef ALU_ISSUE_SKID_EN
      @(negedge clk);
      chk("stl_rdy_two", in_ready, 0);
      drive(7'b0110011, 3'b110, 7'h00, 32'hC0, 32'hC1, 32'd0);
`endif
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk("stl_vld",  out_valid, 1);
         chk("stl_srca", out_srca, 32'hA0);
         chk("stl_srcb", out_srcb, 32'hA1);
         chk("stl_op",   out_operation, 4'b0011);
         chk("stl_rdy",  in_ready, 0);
      end
`ifdef ALU_ISSUE_SKID_EN
      in_valid = 1'b0;
`endif
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("res_vld",  out_valid, 1);
      chk("res_srca", out_srca, 32'hB0);
      chk("res_op",   out_operation, 4'b0000);
      @(negedge clk);
      exp_cnt = exp_cnt + 32'd2;
      chk("res_end", out_valid, 0);
      chk("res_cnt", out_issue_cnt, exp_cnt);
      out_ready = 1'b0;

      // counter wrap
      @(negedge clk);
      force dut.out_issue_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.out_issue_cnt;
      #1;
      chk("wrap_pre", out_issue_cnt, 32'hFFFF_FFFF);
      exp_cnt = 32'hFFFF_FFFF;
      send_check("wrap", 7'b0110011, 3'b100, 7'h00, 32'h5, 32'h6, 32'd0,
                 4'b0110, 32'h5, 32'h6, 1'b0, 1'b0);

      // reset while entries are held
      @(negedge clk);
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 7'h00, 32'hD0, 32'hD1, 32'd0);
      in_valid = 1'b1;
      @(negedge clk);
      drive(7'b0110011, 3'b000, 7'h00, 32'hE0, 32'hE1, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("prerst_vld", out_valid, 1);
      chk("prerst_cnt", out_issue_cnt, exp_cnt);
      reset = 1'b1;
      #1;
      chk("mrst_vld",  out_valid, 0);
      chk("mrst_cnt",  out_issue_cnt, 0);
      chk("mrst_rdy",  in_ready, 0);
      chk("mrst_srca", out_srca, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 32'd0;
      @(negedge clk);
      chk("post_rdy", in_ready, 1);
      chk("post_vld", out_valid, 0);
      chk("post_cnt", out_issue_cnt, exp_cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
